// File: rtl/clk_meas_pkg.sv
// -----------------------------------------------------------------------------
// clk_meas_pkg
// Shared types and constants for the period-measurement block.
//   meas_state_e           : measurement state machine encoding
//   CNT_W_DEFAULT          : default period counter width
//   TIMEOUT_CYCLES_DEFAULT : default no-edge timeout, in system clock cycles
//   AVG_DEPTH / AVG_SHIFT  : averaging window depth and matching divide shift
// -----------------------------------------------------------------------------
package clk_meas_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MEASURE = 2'd1,
        TIMEOUT = 2'd2
    } meas_state_e;

    localparam int              CNT_W_DEFAULT          = 33;
    localparam longint unsigned TIMEOUT_CYCLES_DEFAULT = 64'd50_000_000;

    // Window depth must stay a power of two so the mean is a plain shift.
    localparam int AVG_DEPTH  = 4;
    localparam int AVG_SHIFT  = $clog2(AVG_DEPTH);
    localparam int AVG_IDX_W  = AVG_SHIFT;
    localparam int AVG_FILL_W = AVG_SHIFT + 1;

endpackage

// File: rtl/sig_sync_edge.sv
// -----------------------------------------------------------------------------
// sig_sync_edge
// Multi-flop synchroniser for an asynchronous pin followed by a rising-edge
// detector. Reusable for any slow external input sampled in i_clkPin's domain.
//
// Parameters:
//   SYNC_STAGES : synchroniser depth, minimum 2.
// Ports:
//   i_clkPin  in  1  system clock, rising edge
//   i_rstNPin in  1  asynchronous active-low reset
//   i_sigPin  in  1  asynchronous input pin
//   rise      out 1  high for one cycle per synchronised rising edge
//
// An i_sigPin rise is acted upon by downstream logic SYNC_STAGES+1 clock
// edges after it is first sampled. The chain runs unconditionally so a
// consumer that ignores rise for a while never sees a stale edge later.
// -----------------------------------------------------------------------------
module sig_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic i_clkPin,
    input  logic i_rstNPin,
    input  logic i_sigPin,
    output logic rise
);

    logic [SYNC_STAGES-1:0] sync_r;
    logic                   prev_r;

    // Synchroniser shift chain plus the previous-value flop for edge detect.
    always_ff @(posedge i_clkPin or negedge i_rstNPin) begin
        if (!i_rstNPin) begin
            sync_r <= '0;
            prev_r <= 1'b0;
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], i_sigPin};
            prev_r <= sync_r[SYNC_STAGES-1];
        end
    end

    // Both operands are flop outputs, so the pulse is glitch-free.
    assign rise = sync_r[SYNC_STAGES-1] & ~prev_r;

endmodule

// File: rtl/clk_period_meter.sv
// -----------------------------------------------------------------------------
// clk_period_meter
// Measures the period of a slow asynchronous square wave (e.g. a divided
// clock) in cycles of i_clkPin. Edges P cycles apart report exactly P.
//
// Parameters:
//   CNT_W          : width of the period counter and of o_period
//   SYNC_STAGES    : synchroniser depth on i_sigPin (minimum 2)
//   TIMEOUT_CYCLES : cycles without a rising edge before o_timeout is raised;
//                    must be below 2**CNT_W so the counter never wraps
// Ports:
//   i_clkPin  in  1      system clock, rising edge
//   i_rstNPin in  1      asynchronous active-low reset
//   i_ena     in  1      measurement enable; low clears back to IDLE
//   i_sigPin  in  1      asynchronous signal to measure
//   o_period  out CNT_W  last measured period (held across disable/timeout)
//   o_valid   out 1      one-cycle pulse when o_period updates
//   o_timeout out 1      level, no rising edge for TIMEOUT_CYCLES
//
// Build option CLK_PERIOD_METER_AVG_EN: when defined, o_period reports the
// truncated mean of the last 4 periods and o_valid is withheld until 4
// measurements have completed since the last IDLE or TIMEOUT entry.
// -----------------------------------------------------------------------------
module clk_period_meter
    import clk_meas_pkg::*;
#(
    parameter int              CNT_W          = CNT_W_DEFAULT,
    parameter int              SYNC_STAGES    = 2,
    parameter longint unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
    input  logic             i_clkPin,
    input  logic             i_rstNPin,
    input  logic             i_ena,
    input  logic             i_sigPin,
    output logic [CNT_W-1:0] o_period,
    output logic             o_valid,
    output logic             o_timeout
);

    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] ONE_C     = CNT_W'(1);

    logic             rise_s;
    meas_state_e      state_r;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_inc_s;
    logic [CNT_W-1:0] period_r;
    logic             valid_r;
    logic             timeout_r;

    sig_sync_edge #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .i_clkPin  (i_clkPin),
        .i_rstNPin (i_rstNPin),
        .i_sigPin  (i_sigPin),
        .rise      (rise_s)
    );

    // cnt_r holds (cycles since reference edge) - 1, so cnt+1 is the period.
    always_comb begin
        cnt_inc_s = cnt_r + ONE_C;
    end

`ifdef CLK_PERIOD_METER_AVG_EN
    logic [CNT_W+1:0]       avg_sum_r;
    logic [CNT_W+1:0]       avg_sum_next_s;
    logic [CNT_W-1:0]       avg_win_r [AVG_DEPTH];
    logic [AVG_IDX_W-1:0]   avg_idx_r;
    logic [AVG_FILL_W-1:0]  avg_fill_r;
    logic                   avg_full_s;
    logic                   meas_done_s;
    logic                   win_clear_s;

    // Running sum with the oldest entry swapped out for the new period;
    // the slot being overwritten is the oldest one, or zero while filling.
    always_comb begin
        avg_sum_next_s = avg_sum_r - {2'b00, avg_win_r[avg_idx_r]}
                                   + {2'b00, cnt_inc_s};
        avg_full_s     = (avg_fill_r >= AVG_FILL_W'(AVG_DEPTH - 1));
        meas_done_s    = (state_r == MEASURE) && rise_s;
        win_clear_s    = !i_ena ||
                         ((state_r == MEASURE) && !rise_s && (cnt_inc_s == TIMEOUT_C));
    end

    // Averaging window: cleared on every IDLE or TIMEOUT entry.
    always_ff @(posedge i_clkPin or negedge i_rstNPin) begin
        if (!i_rstNPin) begin
            for (int i = 0; i < AVG_DEPTH; i++) begin
                avg_win_r[i] <= '0;
            end
            avg_sum_r  <= '0;
            avg_idx_r  <= '0;
            avg_fill_r <= '0;
        end else if (win_clear_s) begin
            for (int i = 0; i < AVG_DEPTH; i++) begin
                avg_win_r[i] <= '0;
            end
            avg_sum_r  <= '0;
            avg_idx_r  <= '0;
            avg_fill_r <= '0;
        end else if (meas_done_s) begin
            avg_win_r[avg_idx_r] <= cnt_inc_s;
            avg_sum_r            <= avg_sum_next_s;
            avg_idx_r            <= avg_idx_r + AVG_IDX_W'(1);
            if (avg_fill_r != AVG_FILL_W'(AVG_DEPTH)) begin
                avg_fill_r <= avg_fill_r + AVG_FILL_W'(1);
            end
        end
    end
`endif

    // Measurement state machine with counter and registered outputs.
    always_ff @(posedge i_clkPin or negedge i_rstNPin) begin
        if (!i_rstNPin) begin
            state_r   <= IDLE;
            cnt_r     <= '0;
            period_r  <= '0;
            valid_r   <= 1'b0;
            timeout_r <= 1'b0;
        end else if (!i_ena) begin
            // o_period deliberately keeps its last value while disabled.
            state_r   <= IDLE;
            cnt_r     <= '0;
            valid_r   <= 1'b0;
            timeout_r <= 1'b0;
        end else begin
            valid_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    // First edge only establishes the reference point.
                    cnt_r <= '0;
                    if (rise_s) begin
                        state_r <= MEASURE;
                    end
                end
                MEASURE: begin
                    // A rise takes precedence over a coincident timeout.
                    if (rise_s) begin
`ifdef CLK_PERIOD_METER_AVG_EN
                        if (avg_full_s) begin
                            period_r <= avg_sum_next_s[CNT_W+1:AVG_SHIFT];
                            valid_r  <= 1'b1;
                        end
`else
                        period_r <= cnt_inc_s;
                        valid_r  <= 1'b1;
`endif
                        cnt_r <= '0;
                    end else if (cnt_inc_s == TIMEOUT_C) begin
                        state_r   <= TIMEOUT;
                        timeout_r <= 1'b1;
                    end else begin
                        cnt_r <= cnt_inc_s;
                    end
                end
                TIMEOUT: begin
                    // Abandoned interval is dropped; next edge is a fresh reference.
                    if (rise_s) begin
                        state_r   <= MEASURE;
                        cnt_r     <= '0;
                        timeout_r <= 1'b0;
                    end
                end
                default: begin
                    state_r   <= IDLE;
                    cnt_r     <= '0;
                    timeout_r <= 1'b0;
                end
            endcase
        end
    end

    assign o_period  = period_r;
    assign o_valid   = valid_r;
    assign o_timeout = timeout_r;

endmodule
